// File: rtl/warmboot_pkg.sv
// Shared definitions for the warmboot controller.
//   wb_state_e : controller state encoding
//   SLOT_W     : width of a bitstream slot number
//   cnt_width  : bits needed to hold a cycle count up to a given value
//   max3       : largest of three cycle-count parameters
package warmboot_pkg;

  localparam int SLOT_W = 4;

  typedef enum logic [2:0] {
    S_UNCONF,
    S_RUN,
    S_HOLD,
    S_REQ,
    S_LOAD,
    S_POST,
    S_FAIL
  } wb_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_width(input int unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(longint'(max_val) + 64'd1);
  endfunction

endpackage

// File: rtl/wb_cycle_counter.sv
// Shared cycle counter for the warmboot controller.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load        : load load_value this cycle (highest priority)
//   up          : 1 = saturating up-count (timeout), 0 = down-count to 0
//   load_value  : value loaded on state entry
//   count       : current count
//   tc          : terminal count, high while count == 0
module wb_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         up,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         tc
);

  // Both directions stop at their end value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (up) begin
      if (count != '1) count <= count + 1'b1;
    end else begin
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/warmboot_ctrl.sv
// Warmboot controller: sequences fabric reset, a bitstream load request with one
// fallback retry, and post-load reset release.
//   CLK, reset      : clock, synchronous active-high reset
//   BOOT_top        : warmboot request from the fabric (rising edge, RUN only)
//   SLOT_top        : requested slot, captured on the accepted edge
//   RESET_top       : fabric user-logic reset (high everywhere except RUN)
//   CONFIGURED_top  : fabric holds a valid configuration (high only in RUN)
//   boot_req/ack    : load request handshake to the configuration loader
//   boot_slot       : slot to load
//   config_done/err : single-cycle load result pulses
//   fail            : sticky, fallback load also failed
//   fsm_state       : current controller state, for observation
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int unsigned       RESET_CYCLES      = 16,
  parameter int unsigned       POST_RESET_CYCLES = 8,
  parameter int unsigned       TIMEOUT_CYCLES    = 1048576,
  parameter logic [SLOT_W-1:0] FALLBACK_SLOT     = 4'd0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              BOOT_top,
  input  logic [SLOT_W-1:0] SLOT_top,
  output logic              RESET_top,
  output logic              CONFIGURED_top,
  output logic              boot_req,
  output logic [SLOT_W-1:0] boot_slot,
  input  logic              boot_ack,
  input  logic              config_done,
  input  logic              config_error,
  output logic              fail,
  output wb_state_e         fsm_state
);

  localparam int CW = cnt_width(max3(RESET_CYCLES, POST_RESET_CYCLES, TIMEOUT_CYCLES));
  // Down-counts load N-1 so the state lasts exactly N cycles; the timeout
  // up-count starts at 0 on LOAD entry, so LOAD lasts at most TIMEOUT_CYCLES.
  localparam logic [CW-1:0] HOLD_LOAD    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] POST_LOAD    = CW'(POST_RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  wb_state_e       state, state_next;
  logic            boot_prev, retried;
  logic            boot_edge, timeout, load_fail;
  logic            capture, retry, give_up;
  logic            cnt_load, cnt_up, tc;
  logic [CW-1:0]   cnt_value, count;

  assign boot_edge = BOOT_top & ~boot_prev;
  assign timeout   = (count == TIMEOUT_LAST);
  assign load_fail = config_error | timeout;

  always_ff @(posedge CLK) begin
    if (reset) state <= S_UNCONF;
    else       state <= state_next;
  end

  // Handshake: boot_req is high for the whole of REQ; the cycle in which
  // boot_ack is sampled high is the last REQ cycle and LOAD follows.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retry      = 1'b0;
    give_up    = 1'b0;
    case (state)
      S_UNCONF: if (config_done) state_next = S_POST;
      S_RUN: begin
        if (boot_edge) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: if (tc) state_next = S_REQ;
      S_REQ:  if (boot_ack) state_next = S_LOAD;
      S_LOAD: begin
        // Error wins over a simultaneous done.
        if (load_fail) begin
          if (retried) begin
            give_up    = 1'b1;
            state_next = S_FAIL;
          end else begin
            retry      = 1'b1;
            state_next = S_HOLD;
          end
        end else if (config_done) begin
          state_next = S_POST;
        end
      end
      S_POST:  if (tc) state_next = S_RUN;
      S_FAIL:  state_next = S_FAIL;
      default: state_next = S_UNCONF;
    endcase
  end

  always_comb begin
    cnt_value = '0;
    case (state_next)
      S_HOLD:  cnt_value = HOLD_LOAD;
      S_POST:  cnt_value = POST_LOAD;
      default: cnt_value = '0;
    endcase
  end

  assign cnt_load = (state_next != state);
  assign cnt_up   = (state == S_LOAD);

  wb_cycle_counter #(.W(CW)) u_counter (
    .clk        (CLK),
    .reset      (reset),
    .load       (cnt_load),
    .up         (cnt_up),
    .load_value (cnt_value),
    .count      (count),
    .tc         (tc)
  );

  // History resets high so a request held through reset is not an edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      boot_prev <= 1'b1;
      boot_slot <= '0;
      retried   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      boot_prev <= BOOT_top;
      if (capture) boot_slot <= SLOT_top;
      if (retry) begin
        boot_slot <= FALLBACK_SLOT;
        retried   <= 1'b1;
      end
      if (give_up) fail <= 1'b1;
      if (state_next == S_RUN && state != S_RUN) retried <= 1'b0;
    end
  end

  assign RESET_top      = (state != S_RUN);
  assign CONFIGURED_top = (state == S_RUN);
  assign boot_req       = (state == S_REQ);
  assign fsm_state      = state;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Testbench for warmboot_ctrl: scenario tasks driven from one initial block,
// checked against a transaction-level model of which slots get requested and
// how each warmboot ends.
module tb_warmboot_ctrl;
  import warmboot_pkg::*;

  localparam int          RC     = 16;
  localparam int          PRC    = 8;
  localparam int          TO     = 64;
  localparam logic [3:0]  FB     = 4'd0;
  localparam int          BUDGET = 200;
  localparam int K_DONE = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  logic       clk = 1'b0;
  logic       reset, BOOT_top, boot_ack, config_done, config_error;
  logic [3:0] SLOT_top;
  logic       RESET_top, CONFIGURED_top, boot_req, fail;
  logic [3:0] boot_slot;
  wb_state_e  fsm_state;

  int errors = 0;
  int checks = 0;

  // Model output: slots expected to be requested, in order, and final outcome.
  logic [3:0] exp_q[$];
  bit         exp_fail;

  // Observations recorded by the driver.
  logic [3:0] obs_slot[$];
  int         obs_hold[$];
  int         obs_post;
  bit         obs_req_ok, obs_rst_ok, obs_fail;

  warmboot_ctrl #(
    .RESET_CYCLES      (RC),
    .POST_RESET_CYCLES (PRC),
    .TIMEOUT_CYCLES    (TO),
    .FALLBACK_SLOT     (FB)
  ) dut (
    .CLK            (clk),
    .reset          (reset),
    .BOOT_top       (BOOT_top),
    .SLOT_top       (SLOT_top),
    .RESET_top      (RESET_top),
    .CONFIGURED_top (CONFIGURED_top),
    .boot_req       (boot_req),
    .boot_slot      (boot_slot),
    .boot_ack       (boot_ack),
    .config_done    (config_done),
    .config_error   (config_error),
    .fail           (fail),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // A load fails on error, on done+error together, or on no answer at all.
  function automatic bit is_failure(input int kind);
    return kind != K_DONE;
  endfunction

  task automatic model_boot(input logic [3:0] slot, input int k1, input int k2);
    exp_q.delete();
    exp_fail = 1'b0;
    exp_q.push_back(slot);
    if (is_failure(k1)) begin
      exp_q.push_back(FB);
      if (is_failure(k2)) exp_fail = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  // Issues one warmboot from RUN and plays the loader for up to two attempts.
  task automatic run_boot(input logic [3:0] slot, input int ack_dly, input int resp_dly,
                          input int k1, input int k2, input bit noise);
    int         kinds[2];
    int         n;
    logic [3:0] held;
    kinds[0] = k1;
    kinds[1] = k2;
    obs_slot.delete();
    obs_hold.delete();
    obs_post   = -1;
    obs_req_ok = 1'b1;
    obs_rst_ok = 1'b1;
    obs_fail   = 1'b0;
    SLOT_top = slot;
    BOOT_top = 1'b1;
    tick();
    SLOT_top = ~slot;
    for (int a = 0; a < 2; a++) begin
      n = 0;
      while (boot_req !== 1'b1 && n < BUDGET) begin
        if (RESET_top !== 1'b1 || CONFIGURED_top !== 1'b0) obs_rst_ok = 1'b0;
        if (noise) begin
          SLOT_top    = 4'($urandom);
          BOOT_top    = 1'($urandom);
          config_done = ($urandom_range(0, 5) == 0);
        end
        tick();
        n++;
        config_done = 1'b0;
      end
      obs_hold.push_back(n);
      BOOT_top = 1'b0;
      if (boot_req !== 1'b1) begin
        obs_req_ok = 1'b0;
        return;
      end
      held = boot_slot;
      obs_slot.push_back(held);
      for (int k = 0; k < ack_dly; k++) begin
        SLOT_top = 4'($urandom);
        tick();
        if (boot_req !== 1'b1 || boot_slot !== held) obs_req_ok = 1'b0;
      end
      boot_ack = 1'b1;
      tick();
      boot_ack = 1'b0;
      if (boot_req !== 1'b0 || boot_slot !== held) obs_req_ok = 1'b0;
      if (kinds[a] == K_NONE) begin
        repeat (TO) tick();
      end else begin
        repeat (resp_dly) tick();
        config_done  = (kinds[a] != K_ERR);
        config_error = (kinds[a] != K_DONE);
        tick();
        config_done  = 1'b0;
        config_error = 1'b0;
      end
      if (kinds[a] == K_DONE) begin
        n = 0;
        while (CONFIGURED_top !== 1'b1 && n < BUDGET) begin
          if (RESET_top !== 1'b1) obs_rst_ok = 1'b0;
          tick();
          n++;
        end
        obs_post = n;
        return;
      end
      obs_fail = fail;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; BOOT_top = 1'b1; SLOT_top = 4'd9;
    boot_ack = 1'b0; config_done = 1'b0; config_error = 1'b0;
    repeat (3) tick();
    checks++; if (RESET_top !== 1'b1) begin errors++; $display("FAIL reset RESET_top: got %b want 1", RESET_top); end
    checks++; if (CONFIGURED_top !== 1'b0) begin errors++; $display("FAIL reset CONFIGURED_top: got %b want 0", CONFIGURED_top); end
    checks++; if (boot_req !== 1'b0) begin errors++; $display("FAIL reset boot_req: got %b want 0", boot_req); end
    checks++; if (boot_slot !== 4'd0) begin errors++; $display("FAIL reset boot_slot: got %0d want 0", boot_slot); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset fail: got %b want 0", fail); end
    checks++; if (fsm_state !== S_UNCONF) begin errors++; $display("FAIL reset state: got %0d want %0d", fsm_state, S_UNCONF); end
  endtask

  task automatic test_power_on();
    int n;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (RESET_top !== 1'b1 || boot_req !== 1'b0) begin errors++; $display("FAIL power_on unconf: got rst=%b req=%b want rst=1 req=0", RESET_top, boot_req); end
    end
    config_done = 1'b1;
    tick();
    config_done = 1'b0;
    n = 0;
    while (CONFIGURED_top !== 1'b1 && n < BUDGET) begin tick(); n++; end
    checks++; if (n != PRC) begin errors++; $display("FAIL power_on post_len: got %0d want %0d", n, PRC); end
    checks++; if (RESET_top !== 1'b0) begin errors++; $display("FAIL power_on RESET_top: got %b want 0", RESET_top); end
    // BOOT_top has been high since reset: no edge, so no boot.
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (CONFIGURED_top !== 1'b1 || RESET_top !== 1'b0) begin errors++; $display("FAIL power_on held_boot: got conf=%b rst=%b want conf=1 rst=0", CONFIGURED_top, RESET_top); end
    end
    BOOT_top = 1'b0;
    tick();
  endtask

  task automatic test_warmboot();
    model_boot(4'd3, K_DONE, K_DONE);
    run_boot(4'd3, 4, 2, K_DONE, K_DONE, 1'b0);
    checks++; if (obs_slot.size() != exp_q.size()) begin errors++; $display("FAIL warmboot req_count: got %0d want %0d", obs_slot.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_slot.size()) begin
      checks++; if (obs_slot[i] !== exp_q[i]) begin errors++; $display("FAIL warmboot slot%0d: got %0d want %0d", i, obs_slot[i], exp_q[i]); end
    end
    foreach (obs_hold[i]) begin
      checks++; if (obs_hold[i] != RC) begin errors++; $display("FAIL warmboot hold%0d: got %0d want %0d", i, obs_hold[i], RC); end
    end
    checks++; if (obs_post != PRC) begin errors++; $display("FAIL warmboot post_len: got %0d want %0d", obs_post, PRC); end
    checks++; if (!obs_req_ok) begin errors++; $display("FAIL warmboot handshake: got 0 want 1"); end
    checks++; if (!obs_rst_ok) begin errors++; $display("FAIL warmboot reset_window: got 0 want 1"); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL warmboot fail: got %b want 0", fail); end
  endtask

  task automatic test_retry(input string name, input int k1);
    logic [3:0] s;
    s = 4'($urandom_range(1, 15));
    model_boot(s, k1, K_DONE);
    run_boot(s, $urandom_range(0, 5), $urandom_range(0, 10), k1, K_DONE, 1'b0);
    checks++; if (obs_slot.size() != exp_q.size()) begin errors++; $display("FAIL %s req_count: got %0d want %0d", name, obs_slot.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_slot.size()) begin
      checks++; if (obs_slot[i] !== exp_q[i]) begin errors++; $display("FAIL %s slot%0d: got %0d want %0d", name, i, obs_slot[i], exp_q[i]); end
    end
    foreach (obs_hold[i]) begin
      checks++; if (obs_hold[i] != RC) begin errors++; $display("FAIL %s hold%0d: got %0d want %0d", name, i, obs_hold[i], RC); end
    end
    checks++; if (obs_post != PRC) begin errors++; $display("FAIL %s post_len: got %0d want %0d", name, obs_post, PRC); end
    checks++; if (fail !== exp_fail) begin errors++; $display("FAIL %s fail: got %b want %b", name, fail, exp_fail); end
    checks++; if (!obs_req_ok || !obs_rst_ok) begin errors++; $display("FAIL %s protocol: got req_ok=%b rst_ok=%b want 1 1", name, obs_req_ok, obs_rst_ok); end
  endtask

  task automatic test_error_retry();
    test_retry("error_retry", K_ERR);
  endtask

  task automatic test_same_cycle();
    test_retry("same_cycle", K_BOTH);
  endtask

  task automatic test_random();
    logic [3:0] s;
    int         k1;
    for (int it = 0; it < 6; it++) begin
      s  = 4'($urandom);
      k1 = $urandom_range(0, 3);
      model_boot(s, k1, K_DONE);
      run_boot(s, $urandom_range(0, 5), $urandom_range(0, 10), k1, K_DONE, 1'b1);
      checks++; if (obs_slot.size() != exp_q.size()) begin errors++; $display("FAIL random%0d req_count: got %0d want %0d", it, obs_slot.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_slot.size()) begin
        checks++; if (obs_slot[i] !== exp_q[i]) begin errors++; $display("FAIL random%0d slot%0d: got %0d want %0d", it, i, obs_slot[i], exp_q[i]); end
      end
      foreach (obs_hold[i]) begin
        checks++; if (obs_hold[i] != RC) begin errors++; $display("FAIL random%0d hold%0d: got %0d want %0d", it, i, obs_hold[i], RC); end
      end
      checks++; if (obs_post != PRC) begin errors++; $display("FAIL random%0d post_len: got %0d want %0d", it, obs_post, PRC); end
      checks++; if (fail !== exp_fail || !obs_req_ok || !obs_rst_ok) begin errors++; $display("FAIL random%0d status: got fail=%b req_ok=%b rst_ok=%b want %b 1 1", it, fail, obs_req_ok, obs_rst_ok, exp_fail); end
    end
  endtask

  task automatic test_double_failure();
    logic [3:0] s;
    s = 4'($urandom_range(1, 15));
    model_boot(s, K_NONE, K_NONE);
    run_boot(s, $urandom_range(0, 5), 0, K_NONE, K_NONE, 1'b0);
    checks++; if (obs_slot.size() != exp_q.size()) begin errors++; $display("FAIL double_fail req_count: got %0d want %0d", obs_slot.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_slot.size()) begin
      checks++; if (obs_slot[i] !== exp_q[i]) begin errors++; $display("FAIL double_fail slot%0d: got %0d want %0d", i, obs_slot[i], exp_q[i]); end
    end
    foreach (obs_hold[i]) begin
      checks++; if (obs_hold[i] != RC) begin errors++; $display("FAIL double_fail hold%0d: got %0d want %0d", i, obs_hold[i], RC); end
    end
    checks++; if (obs_fail !== exp_fail) begin errors++; $display("FAIL double_fail fail: got %b want %b", obs_fail, exp_fail); end
    checks++; if (obs_post != -1) begin errors++; $display("FAIL double_fail post_len: got %0d want -1", obs_post); end
    checks++; if (fsm_state !== S_FAIL || RESET_top !== 1'b1 || CONFIGURED_top !== 1'b0) begin errors++; $display("FAIL double_fail outputs: got state=%0d rst=%b conf=%b want %0d 1 0", fsm_state, RESET_top, CONFIGURED_top, S_FAIL); end
    // A new request edge and stray results must not leave FAIL.
    BOOT_top = 1'b1;
    for (int i = 0; i < 25; i++) begin
      config_done = (i % 7 == 3);
      tick();
      config_done = 1'b0;
      checks++; if (boot_req !== 1'b0 || fail !== 1'b1 || RESET_top !== 1'b1) begin errors++; $display("FAIL double_fail terminal: got req=%b fail=%b rst=%b want 0 1 1", boot_req, fail, RESET_top); end
    end
    BOOT_top = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL mid_load fail_cleared: got %b want 0", fail); end
    config_done = 1'b1;
    tick();
    config_done = 1'b0;
    n = 0;
    while (CONFIGURED_top !== 1'b1 && n < BUDGET) begin tick(); n++; end
    checks++; if (n != PRC) begin errors++; $display("FAIL mid_load power_on: got %0d want %0d", n, PRC); end
    SLOT_top = 4'd5;
    BOOT_top = 1'b1;
    tick();
    n = 0;
    while (boot_req !== 1'b1 && n < BUDGET) begin tick(); n++; end
    checks++; if (n != RC) begin errors++; $display("FAIL mid_load hold: got %0d want %0d", n, RC); end
    boot_ack = 1'b1;
    tick();
    boot_ack = 1'b0;
    tick();
    checks++; if (fsm_state !== S_LOAD) begin errors++; $display("FAIL mid_load in_load: got %0d want %0d", fsm_state, S_LOAD); end
    reset = 1'b1;
    tick();
    checks++; if (boot_req !== 1'b0 || fsm_state !== S_UNCONF || boot_slot !== 4'd0 || RESET_top !== 1'b1) begin errors++; $display("FAIL mid_load reset: got req=%b state=%0d slot=%0d rst=%b want 0 %0d 0 1", boot_req, fsm_state, boot_slot, RESET_top, S_UNCONF); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (boot_req !== 1'b0 || fsm_state !== S_UNCONF) begin errors++; $display("FAIL mid_load after_release: got req=%b state=%0d want 0 %0d", boot_req, fsm_state, S_UNCONF); end
    end
    // Bring the fabric up with BOOT_top still held: RUN must stay put.
    config_done = 1'b1;
    tick();
    config_done = 1'b0;
    repeat (PRC + 10) begin
      tick();
      checks++; if (boot_req !== 1'b0) begin errors++; $display("FAIL mid_load spurious_req: got %b want 0", boot_req); end
    end
    checks++; if (fsm_state !== S_RUN) begin errors++; $display("FAIL mid_load final_state: got %0d want %0d", fsm_state, S_RUN); end
    BOOT_top = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_warmboot();
    test_error_retry();
    test_same_cycle();
    test_random();
    test_double_failure();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/warmboot_ctrl.md
WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: the number of cycles RESET_top is held before a load request is issued.
REQ-002 SHALL have parameter POST_RESET_CYCLES, default 8: the number of cycles RESET_top stays high after config_done.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: the maximum number of cycles to wait for config_done or config_error.
REQ-004 SHALL have parameter FALLBACK_SLOT, default 4'd0: the slot used on retry after a failure.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port BOOT_top, input, 1 bit: warmboot request from the fabric tile, synchronous to CLK.
REQ-008 SHALL have port SLOT_top, input, 4 bits: bitstream slot requested by the fabric.
REQ-009 SHALL have port RESET_top, output, 1 bit: fabric user-logic reset to the tile.
REQ-010 SHALL have port CONFIGURED_top, output, 1 bit: the fabric holds a valid configuration.
REQ-011 SHALL have port boot_req, output, 1 bit: load request to the configuration loader.
REQ-012 SHALL have port boot_slot, output, 4 bits: the slot to load; stable while boot_req is high.
REQ-013 SHALL have port boot_ack, input, 1 bit: the loader accepts the request.
REQ-014 SHALL have port config_done, input, 1 bit: single-cycle pulse, load finished OK.
REQ-015 SHALL have port config_error, input, 1 bit: single-cycle pulse, load failed.
REQ-016 SHALL have port fail, output, 1 bit: sticky error; set when the fallback load also failed.

Function
REQ-017 SHALL implement the FSM states UNCONF, RUN, HOLD, REQ, LOAD, POST and FAIL.
REQ-018 UNCONF SHALL drive RESET_top=1 and CONFIGURED_top=0, and go to POST when config_done=1 (initial power-on load).
REQ-019 In RUN, RESET_top SHALL be 0 and CONFIGURED_top SHALL be 1.
REQ-020 In RUN, a BOOT_top rising edge (registered copy 0, current 1) SHALL capture SLOT_top into boot_slot and move to HOLD.
REQ-021 RESET_top SHALL be 1 and CONFIGURED_top SHALL be 0 from the first HOLD cycle, which is the cycle after the edge is sampled.
REQ-022 BOOT_top edges outside RUN SHALL be ignored.
REQ-023 SLOT_top changes after the capture SHALL be ignored.
REQ-024 HOLD SHALL last exactly RESET_CYCLES cycles, then go to REQ.
REQ-025 REQ SHALL assert boot_req until the cycle in which boot_ack=1; the FSM SHALL then be in LOAD on the next cycle with boot_req=0.
REQ-026 In LOAD, config_done=1 SHALL go to POST.
REQ-027 In LOAD, config_error=1 or the timeout counter reaching TIMEOUT_CYCLES SHALL count as a failure.
REQ-028 If config_done and config_error are high in the same cycle, config_error SHALL take precedence.
REQ-029 On the first failure, boot_slot SHALL be set to FALLBACK_SLOT, the retried flag SHALL be set, and the FSM SHALL go to HOLD.
REQ-030 On a failure with retried already set, the FSM SHALL go to FAIL and set fail=1.
REQ-031 POST SHALL last exactly POST_RESET_CYCLES cycles, then go to RUN with RESET_top=0 and CONFIGURED_top=1 on the same cycle.
REQ-032 Entering RUN SHALL clear the retried flag.
REQ-033 FAIL SHALL be terminal until reset, with RESET_top=1, CONFIGURED_top=0 and boot_req=0.
REQ-034 config_done or config_error seen outside LOAD and UNCONF SHALL be ignored.
REQ-035 The counters SHALL be wide enough for the largest parameter and SHALL saturate, never wrap.
REQ-036 The counters SHALL reload on every state entry.

Reset
REQ-037 reset=1 at any clock edge SHALL force state UNCONF.
REQ-038 reset SHALL force RESET_top=1, CONFIGURED_top=0, boot_req=0, boot_slot=0, fail=0, retried=0, counters=0 and the BOOT_top history register=1.
REQ-039 The BOOT_top history register SHALL reset to 1 so that BOOT_top held high through reset does not cause a boot.
REQ-040 reset in the middle of a load SHALL drop boot_req on the next cycle; no request SHALL be reissued until a later BOOT_top edge.

Structure
REQ-041 Package warmboot_pkg SHALL hold the state encoding, the slot width constant (4) and the counter width function.
REQ-042 Sub-module wb_cycle_counter SHALL be a loadable down-counter with a terminal-count flag and a saturating up-count mode used for the timeout; it is instantiated once and shared by all states.

Verification
REQ-043 Power-on: release reset, pulse config_done at cycle 5 -> RESET_top falls and CONFIGURED_top rises exactly 8 cycles later.
REQ-044 Warmboot: in RUN, SLOT_top=4'd3 with a BOOT_top rise -> RESET_top=1 the next cycle; boot_req=1 with boot_slot=3 after 16 cycles; boot_ack after 4 cycles; config_done -> RUN again 8 cycles later.
REQ-045 Error then retry: first load returns config_error -> second request has boot_slot=0; its config_done -> RUN and fail=0.
REQ-046 Double failure: TIMEOUT_CYCLES=64, no done on either attempt -> FAIL, fail=1, RESET_top held high; a later BOOT_top edge is ignored.
REQ-047 Reset mid-LOAD, with BOOT_top held high through reset -> UNCONF, boot_req=0, and no spurious boot after release.
REQ-048 config_done and config_error high in the same cycle in LOAD -> handled as a failure (retry on slot 0).
